// File: rtl/serial_operand_loader_8_bits.sv
// serial_operand_loader_8_bits: assembles two LSB-first serial bytes into operands A and B
// and holds them for the downstream AND stage until it accepts them.
module serial_operand_loader_8_bits (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       serial_in,
    input  logic       serial_valid,
    input  logic       operands_ready,
    output logic [7:0] A,
    output logic [7:0] B,
    output logic       operands_valid,
    output logic       busy,
    output logic       frame_error
);
    typedef enum logic [1:0] {IDLE, LOAD_A, LOAD_B, PRESENT} state_t;
    state_t     state, state_next;
    logic [2:0] count;
    logic [7:0] sh_a, sh_b;
    logic       clear, take, abort;
    always_comb begin
        state_next = state;
        clear      = 1'b0;
        take       = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: if (start) begin
                state_next = LOAD_A;
                clear      = 1'b1;
            end
            LOAD_A, LOAD_B: if (start) begin
                state_next = LOAD_A;
                clear      = 1'b1;
                abort      = 1'b1;
            end else if (serial_valid) begin
                take = 1'b1;
                if (count == 3'd7) state_next = (state == LOAD_A) ? LOAD_B : PRESENT;
            end
            PRESENT: if (operands_ready) begin
                state_next = start ? LOAD_A : IDLE;
                clear      = start;
            end
            default: state_next = IDLE;
        endcase
    end
    assign operands_valid = (state == PRESENT);
    assign busy           = (state == LOAD_A) || (state == LOAD_B);
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            count       <= 3'd0;
            sh_a        <= 8'h00;
            sh_b        <= 8'h00;
            A           <= 8'h00;
            B           <= 8'h00;
            frame_error <= 1'b0;
        end else begin
            state       <= state_next;
            frame_error <= abort;
            if (clear) begin
                count <= 3'd0;
                sh_a  <= 8'h00;
                sh_b  <= 8'h00;
            end else if (take) begin
                count <= count + 3'd1;
                if (state == LOAD_A) sh_a[count] <= serial_in;
                else sh_b[count] <= serial_in;
                // the final B bit bypasses sh_b so outputs update on the same edge
                if (state == LOAD_B && count == 3'd7) begin
                    A <= sh_a;
                    B <= {serial_in, sh_b[6:0]};
                end
            end
        end
    end
endmodule

// File: tb/tb_serial_operand_loader_8_bits.sv
// tb_serial_operand_loader_8_bits: frame-level model compared every cycle, plus directed literal checks.
module tb_serial_operand_loader_8_bits;
    logic       clk = 1'b0;
    logic       reset = 1'b1, start = 1'b0, serial_in = 1'b0, serial_valid = 1'b0, operands_ready = 1'b0;
    logic [7:0] A, B;
    logic       operands_valid, busy, frame_error;
    int         checks = 0, failures = 0;
    logic       armed = 1'b0;
    int         mode = 0, n = 0;
    logic [15:0] acc = 16'h0;
    logic [7:0] ea = 8'h0, eb = 8'h0;
    logic       eerr = 1'b0;

    serial_operand_loader_8_bits dut (
        .clk(clk), .reset(reset), .start(start), .serial_in(serial_in),
        .serial_valid(serial_valid), .operands_ready(operands_ready),
        .A(A), .B(B), .operands_valid(operands_valid), .busy(busy), .frame_error(frame_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // mode: 0 idle, 1 collecting 16 bits, 2 presenting
    always @(posedge clk) begin
        if (reset) begin
            mode = 0; n = 0; acc = 16'h0; ea = 8'h0; eb = 8'h0; eerr = 1'b0;
        end else begin
            eerr = 1'b0;
            if (mode == 0) begin
                if (start) begin mode = 1; n = 0; acc = 16'h0; end
            end else if (mode == 1) begin
                if (start) begin n = 0; acc = 16'h0; eerr = 1'b1; end
                else if (serial_valid) begin
                    acc[n] = serial_in;
                    n++;
                    if (n == 16) begin mode = 2; ea = acc[7:0]; eb = acc[15:8]; end
                end
            end else if (operands_ready) begin
                if (start) begin mode = 1; n = 0; acc = 16'h0; end
                else mode = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("model_A", A, ea);
            chk("model_B", B, eb);
            chk("model_valid", {7'd0, operands_valid}, {7'd0, mode == 2});
            chk("model_busy", {7'd0, busy}, {7'd0, mode == 1});
            chk("model_ferr", {7'd0, frame_error}, {7'd0, eerr});
        end
    end

    task automatic cyc(input logic s, input logic sv, input logic si, input logic rdy);
        start = s; serial_valid = sv; serial_in = si; operands_ready = rdy;
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] v, input bit gaps);
        for (int i = 0; i < 8; i++) begin
            if (gaps) repeat ($urandom_range(0, 3)) cyc(0, 0, 1'b1, 0);
            cyc(0, 1, v[i], 0);
        end
    endtask

    task automatic frame(input logic [7:0] a, input logic [7:0] b, input bit gaps);
        cyc(1, 0, 0, 0);
        send_byte(a, gaps);
        send_byte(b, gaps);
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        armed = 1'b1;
        chk("reset_A", A, 8'h00);
        chk("reset_busy", {7'd0, busy}, 8'd0);
        cyc(0, 1, 1, 0);
        chk("idle_ignore_busy", {7'd0, busy}, 8'd0);
        // frame 1: A all ones, B all zeros, accepted immediately
        frame(8'hFF, 8'h00, 0);
        chk("s1_valid", {7'd0, operands_valid}, 8'd1);
        chk("s1_A", A, 8'hFF);
        chk("s1_B", B, 8'h00);
        chk("s1_pin_model_A", ea, 8'hFF);
        cyc(0, 0, 0, 1);
        chk("s1_valid_fall", {7'd0, operands_valid}, 8'd0);
        // frame 2: B = A9 with gaps; ready held off for 5 cycles
        cyc(1, 0, 0, 0);
        send_byte(8'hFF, 1);
        send_byte(8'hA9, 1);
        chk("s2_B", B, 8'hA9);
        chk("s2_pin_model_B", eb, 8'hA9);
        for (int i = 0; i < 5; i++) begin
            cyc(i[0], 1, 1, 0);
            chk("s3_hold_valid", {7'd0, operands_valid}, 8'd1);
            chk("s3_hold_A", A, 8'hFF);
        end
        cyc(0, 0, 0, 1);
        chk("s3_release_valid", {7'd0, operands_valid}, 8'd0);
        chk("s3_release_A", A, 8'hFF);
        // abort after 5 A bits; start arrives with a bit that must be discarded
        cyc(1, 1, 1, 0);
        for (int i = 0; i < 5; i++) cyc(0, 1, 1, 0);
        cyc(1, 1, 0, 0);
        chk("s4_ferr_pulse", {7'd0, frame_error}, 8'd1);
        chk("s4_A_kept", A, 8'hFF);
        chk("s4_B_kept", B, 8'hA9);
        cyc(0, 0, 0, 0);
        chk("s4_ferr_drop", {7'd0, frame_error}, 8'd0);
        send_byte(8'h3C, 0);
        send_byte(8'h5A, 1);
        chk("s4_A_new", A, 8'h3C);
        chk("s4_B_new", B, 8'h5A);
        // back-to-back frame from PRESENT
        cyc(1, 0, 0, 1);
        chk("s5_busy", {7'd0, busy}, 8'd1);
        chk("s5_valid", {7'd0, operands_valid}, 8'd0);
        send_byte(8'h96, 0);
        send_byte(8'h0F, 0);
        chk("s5_A", A, 8'h96);
        chk("s5_B", B, 8'h0F);
        cyc(0, 0, 0, 1);
        // reset mid-load after 3 B bits
        cyc(1, 0, 0, 0);
        send_byte(8'h55, 0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0);
        reset = 1'b1;
        cyc(0, 1, 1, 1);
        reset = 1'b0;
        chk("s6_A", A, 8'h00);
        chk("s6_B", B, 8'h00);
        chk("s6_busy", {7'd0, busy}, 8'd0);
        chk("s6_valid", {7'd0, operands_valid}, 8'd0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 1, 0);
        chk("s6_idle_busy", {7'd0, busy}, 8'd0);
        chk("s6_idle_valid", {7'd0, operands_valid}, 8'd0);
        armed = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
